// File: rtl/mem_port_arbiter.sv
// N-port arbiter serialising CPU-style read/write requesters onto one memory port.
// Round-robin or fixed-priority selection; the winning request is latched for the whole transaction.
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned FIXED_PRIORITY = 0
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  port_read,
    input  logic [NUM_PORTS-1:0]                  port_write,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]   port_byte_enable,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]       port_address,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]       port_wdata,
    output logic [NUM_PORTS-1:0]                  port_resp,
    output logic [DATA_WIDTH-1:0]                 port_rdata,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic [(DATA_WIDTH/8)-1:0]             mem_byte_enable,
    output logic [ADDR_WIDTH-1:0]                 mem_address,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic                                  mem_resp,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    output logic                                  busy,
    output logic [$clog2(NUM_PORTS)-1:0]          grant_id
);

    localparam int unsigned IW = $clog2(NUM_PORTS);
    localparam int unsigned BE = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          last_grant_q, last_grant_d;
    logic                   mem_read_q, mem_read_d;
    logic                   mem_write_q, mem_write_d;
    logic [BE-1:0]          be_q, be_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]   port_resp_q, port_resp_d;
    logic                   busy_q, busy_d;

    logic [NUM_PORTS-1:0]   req;
    logic [NUM_PORTS-1:0]   req_sh;
    logic [NUM_PORTS-1:0]   wr_sh;
    int unsigned            idx;
    logic                   any_req;
    logic [IW-1:0]          winner;
    logic                   win_write;
    logic [BE-1:0]          win_be;
    logic [ADDR_WIDTH-1:0]  win_addr;
    logic [DATA_WIDTH-1:0]  win_wdata;

    assign req = port_read | port_write;

    // Winner search: rotating start after the last grant, or from index 0 in fixed-priority mode.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = 0;
        req_sh  = '0;
        for (int unsigned off = 0; off < NUM_PORTS; off++) begin
            if (FIXED_PRIORITY != 0) begin
                idx = off;
            end else begin
                idx = (32'(last_grant_q) + off + 1) % NUM_PORTS;
            end
            req_sh = req >> idx;
            if (!any_req && req_sh[0]) begin
                any_req = 1'b1;
                winner  = IW'(idx);
            end
        end
    end

    // Payload of the selected port; write wins when both read and write are raised.
    always_comb begin
        wr_sh     = port_write >> winner;
        win_write = wr_sh[0];
        win_be    = BE'(port_byte_enable >> (32'(winner) * BE));
        win_addr  = ADDR_WIDTH'(port_address >> (32'(winner) * ADDR_WIDTH));
        win_wdata = DATA_WIDTH'(port_wdata >> (32'(winner) * DATA_WIDTH));
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        port_resp_d  = '0;
        busy_d       = busy_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_d      = winner;
                    last_grant_d = winner;
                    mem_write_d  = win_write;
                    mem_read_d   = !win_write;
                    be_d         = win_be;
                    addr_d       = win_addr;
                    wdata_d      = win_wdata;
                    busy_d       = 1'b1;
                    state_d      = S_BUSY;
                end
            end
            S_BUSY: begin
                if (mem_resp) begin
                    if (!mem_write_q) begin
                        rdata_d = mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    port_resp_d = NUM_PORTS'(1) << grant_q;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_PORTS - 1);
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rdata_q      <= '0;
            port_resp_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
            port_resp_q  <= port_resp_d;
            busy_q       <= busy_d;
        end
    end

    assign port_resp       = port_resp_q;
    assign port_rdata      = rdata_q;
    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = be_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign busy            = busy_q;
    assign grant_id        = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: 2-port round-robin instance plus a 4-port fixed-priority instance.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    // 2-port round-robin instance
    logic [1:0]  rd_a, wr_a, resp_a;
    logic [7:0]  be_a;
    logic [63:0] addr_a, wdata_a;
    logic [31:0] rdata_a, maddr_a, mwdata_a, mem_rdata_a;
    logic        mrd_a, mwr_a, busy_a, mem_resp_a;
    logic [3:0]  mbe_a;
    logic [0:0]  gid_a;

    // 4-port fixed-priority instance
    logic [3:0]   rd_b, wr_b, resp_b;
    logic [15:0]  be_b;
    logic [127:0] addr_b, wdata_b;
    logic [31:0]  rdata_b, maddr_b, mwdata_b, mem_rdata_b;
    logic         mrd_b, mwr_b, busy_b, mem_resp_b;
    logic [3:0]   mbe_b;
    logic [1:0]   gid_b;

    int n_vec = 0;
    int n_err = 0;
    int lat   = 1;
    int cnt_a = 0;

    mem_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(0)) dut (
        .clk(clk), .rst(rst),
        .port_read(rd_a), .port_write(wr_a), .port_byte_enable(be_a),
        .port_address(addr_a), .port_wdata(wdata_a),
        .port_resp(resp_a), .port_rdata(rdata_a),
        .mem_read(mrd_a), .mem_write(mwr_a), .mem_byte_enable(mbe_a),
        .mem_address(maddr_a), .mem_wdata(mwdata_a),
        .mem_resp(mem_resp_a), .mem_rdata(mem_rdata_a),
        .busy(busy_a), .grant_id(gid_a)
    );

    mem_port_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .FIXED_PRIORITY(1)) dut_fp (
        .clk(clk), .rst(rst),
        .port_read(rd_b), .port_write(wr_b), .port_byte_enable(be_b),
        .port_address(addr_b), .port_wdata(wdata_b),
        .port_resp(resp_b), .port_rdata(rdata_b),
        .mem_read(mrd_b), .mem_write(mwr_b), .mem_byte_enable(mbe_b),
        .mem_address(maddr_b), .mem_wdata(mwdata_b),
        .mem_resp(mem_resp_b), .mem_rdata(mem_rdata_b),
        .busy(busy_b), .grant_id(gid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Memory model A: responds after 'lat' request cycles, data = address+1 (0x40 returns 0xDEADBEEF)
    initial begin
        mem_resp_a  = 1'b0;
        mem_rdata_a = '0;
        forever begin
            @(negedge clk);
            if (mrd_a || mwr_a) cnt_a++;
            else cnt_a = 0;
            mem_resp_a  = (cnt_a == lat);
            mem_rdata_a = !mem_resp_a ? 32'h0 :
                          (maddr_a == 32'h40) ? 32'hDEAD_BEEF : maddr_a + 32'h1;
        end
    end

    // Memory model B: zero-wait
    initial begin
        mem_resp_b  = 1'b0;
        mem_rdata_b = 32'h5555_0000;
        forever begin
            @(negedge clk);
            mem_resp_b = mrd_b || mwr_b;
        end
    end

    int          pc   [4];
    logic [3:0]  pv   [4];
    logic [1:0]  pg   [4];
    logic [31:0] pd   [4];
    int          np;
    logic [31:0] exp_rdata;

    initial begin
        rst = 1'b0;
        rd_a = '0; wr_a = '0; be_a = '0; addr_a = '0; wdata_a = '0;
        rd_b = '0; wr_b = '0; be_b = '0; addr_b = '0; wdata_b = '0;
        cyc();
        chk("rst_mem_read", mrd_a, 0);
        chk("rst_mem_write", mwr_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_grant", gid_a, 0);
        chk("rst_rdata", rdata_a, 0);
        chk("rst_port_resp", resp_a, 0);
        chk("rst_mem_addr_be", {maddr_a, mbe_a}, 0);
        cyc();
        rst = 1'b1;
        cyc();

        // Single read, 3-cycle memory
        lat = 3;
        addr_a[31:0] = 32'h40; be_a[3:0] = 4'hF; rd_a = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk($sformatf("rd_mem_read_c%0d", c), mrd_a, 1);
            chk($sformatf("rd_mem_addr_c%0d", c), maddr_a, 32'h40);
            chk($sformatf("rd_resp_c%0d", c), resp_a, 0);
        end
        chk("rd_busy", busy_a, 1);
        cyc();
        chk("rd_port_resp", resp_a, 2'b01);
        chk("rd_rdata", rdata_a, 32'hDEAD_BEEF);
        chk("rd_mem_read_low", mrd_a, 0);
        rd_a = 2'b00;
        cyc();
        chk("rd_resp_one_cycle", resp_a, 0);
        chk("rd_rdata_hold", rdata_a, 32'hDEAD_BEEF);
        chk("rd_idle_busy", busy_a, 0);

        // Round-robin contention from reset, zero-wait memory
        rst = 1'b0; cyc(); rst = 1'b1; cyc();
        lat = 1;
        addr_a = {32'h0000_2000, 32'h0000_1000};
        rd_a = 2'b11;
        np = 0;
        for (int c = 1; c <= 30 && np < 4; c++) begin
            cyc();
            if (resp_a != 0) begin
                pc[np] = c; pv[np] = 4'(resp_a); pg[np] = 2'(gid_a); pd[np] = rdata_a;
                np++;
                if (np == 4) rd_a = 2'b00;
            end
        end
        chk("rr_pulse_count", np, 4);
        for (int j = 0; j < np; j++) begin
            chk($sformatf("rr_resp_%0d", j), pv[j], (j % 2 == 0) ? 4'b0001 : 4'b0010);
            chk($sformatf("rr_grant_%0d", j), pg[j], 2'(j % 2));
            chk($sformatf("rr_rdata_%0d", j), pd[j], (j % 2 == 0) ? 32'h1001 : 32'h2001);
            if (j == 0) chk("rr_first_latency", pc[0], 2);
            else chk($sformatf("rr_spacing_%0d", j), pc[j] - pc[j-1], 3);
        end
        exp_rdata = 32'h2001;
        cyc();

        // Fixed priority: ports 1 and 3 contend, port 1 drops after three grants
        addr_b = {32'h3000, 32'h2000, 32'h1000, 32'h0};
        rd_b = 4'b1010;
        np = 0;
        for (int c = 1; c <= 40 && np < 4; c++) begin
            cyc();
            if (resp_b != 0) begin
                pv[np] = resp_b; pg[np] = gid_b;
                np++;
                if (np == 3) rd_b = 4'b1000;
                if (np == 4) rd_b = 4'b0000;
            end
        end
        chk("fp_pulse_count", np, 4);
        for (int j = 0; j < np; j++) begin
            chk($sformatf("fp_resp_%0d", j), pv[j], (j < 3) ? 4'b0010 : 4'b1000);
            chk($sformatf("fp_grant_%0d", j), pg[j], (j < 3) ? 2'd1 : 2'd3);
        end
        cyc();

        // Byte-enable write from port 1, 2-cycle memory
        lat = 2;
        addr_a[63:32] = 32'h100; wdata_a[63:32] = 32'h1234_5678; be_a[7:4] = 4'b0011;
        wr_a = 2'b10;
        for (int c = 1; c <= 2; c++) begin
            cyc();
            chk($sformatf("wr_mem_write_c%0d", c), mwr_a, 1);
            chk($sformatf("wr_mem_read_c%0d", c), mrd_a, 0);
            chk($sformatf("wr_be_c%0d", c), mbe_a, 4'b0011);
            chk($sformatf("wr_wdata_c%0d", c), mwdata_a, 32'h1234_5678);
            chk($sformatf("wr_addr_c%0d", c), maddr_a, 32'h100);
        end
        cyc();
        chk("wr_port_resp", resp_a, 2'b10);
        chk("wr_rdata_kept", rdata_a, exp_rdata);
        wr_a = 2'b00;
        cyc();

        // Read+write on port 0 is one write; requester drops mid-BUSY
        lat = 1;
        addr_a[31:0] = 32'h200; wdata_a[31:0] = 32'hA5A5_A5A5; be_a[3:0] = 4'hF;
        rd_a = 2'b01; wr_a = 2'b01;
        cyc();
        chk("rw_mem_write", mwr_a, 1);
        chk("rw_mem_read", mrd_a, 0);
        chk("rw_wdata", mwdata_a, 32'hA5A5_A5A5);
        rd_a = 2'b00; wr_a = 2'b00;
        cyc();
        chk("rw_port_resp", resp_a, 2'b01);
        chk("rw_rdata_kept", rdata_a, exp_rdata);
        cyc();
        chk("rw_single_txn", {mrd_a, mwr_a, resp_a}, 0);
        cyc();
        chk("rw_no_second_txn", {mrd_a, mwr_a, busy_a}, 0);

        // Asynchronous reset in the middle of a BUSY read
        lat = 5;
        addr_a[63:32] = 32'h300; rd_a = 2'b10;
        cyc();
        chk("ar_mem_read_before", mrd_a, 1);
        chk("ar_grant_before", gid_a, 1);
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("ar_mem_read", mrd_a, 0);
        chk("ar_busy", busy_a, 0);
        chk("ar_grant", gid_a, 0);
        chk("ar_mem_addr", maddr_a, 0);
        chk("ar_mem_be", mbe_a, 0);
        chk("ar_rdata", rdata_a, 0);
        chk("ar_port_resp", resp_a, 0);
        rd_a = 2'b00;
        cyc();
        rst = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            cyc();
            chk($sformatf("ar_no_resp_c%0d", c), {resp_a, mrd_a}, 0);
        end
        lat = 1;
        addr_a = {32'h0000_0500, 32'h0000_0400};
        rd_a = 2'b11;
        cyc();
        chk("ar_post_grant", gid_a, 0);
        chk("ar_post_addr", maddr_a, 32'h400);
        cyc();
        chk("ar_post_resp", resp_a, 2'b01);
        chk("ar_post_rdata", rdata_a, 32'h401);
        rd_a = 2'b00;
        cyc();
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
